// File: rtl/classify_calibrate.sv
// Two-class IQ calibration: averages N labelled samples per class and derives the
// midpoint and separation vector of the two centroids for a linear classifier.
module classify_calibrate #(
    parameter int LOG2_N = 4
) (
    input  logic               clk100,
    input  logic               rst,
    input  logic               start,
    input  logic               data_in,
    input  logic               label,
    input  logic signed [31:0] i_val,
    input  logic signed [31:0] q_val,
    output logic signed [31:0] i_pt_line,
    output logic signed [31:0] q_pt_line,
    output logic signed [31:0] i_vec_perp,
    output logic signed [31:0] q_vec_perp,
    output logic               cal_valid,
    output logic               busy
);
    localparam int ACC_W = 32 + LOG2_N;
    localparam logic [LOG2_N:0] FULL = {1'b1, {LOG2_N{1'b0}}};
    localparam logic [LOG2_N:0] ONE  = {{LOG2_N{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, COLLECT, COMPUTE, DONE} state_t;
    state_t state;

    logic signed [ACC_W-1:0] acc0_i, acc0_q, acc1_i, acc1_q;
    logic [LOG2_N:0]         cnt0, cnt1;
    logic signed [ACC_W-1:0] ext_i, ext_q;
    logic signed [31:0]      c0_i, c0_q, c1_i, c1_q;
    logic signed [32:0]      sum_i, sum_q;
    logic signed [31:0]      pt_i, pt_q, vec_i, vec_q;

    always_comb begin
        ext_i = {{LOG2_N{i_val[31]}}, i_val};
        ext_q = {{LOG2_N{q_val[31]}}, q_val};
        c0_i  = 32'(acc0_i >>> LOG2_N);
        c0_q  = 32'(acc0_q >>> LOG2_N);
        c1_i  = 32'(acc1_i >>> LOG2_N);
        c1_q  = 32'(acc1_q >>> LOG2_N);
        // 33-bit sum so the midpoint cannot overflow before the halving shift
        sum_i = {c0_i[31], c0_i} + {c1_i[31], c1_i};
        sum_q = {c0_q[31], c0_q} + {c1_q[31], c1_q};
        pt_i  = 32'(sum_i >>> 1);
        pt_q  = 32'(sum_q >>> 1);
        vec_i = c1_i - c0_i;
        vec_q = c1_q - c0_q;
    end

    // A sample is taken on every edge with data_in=1 while collecting and its class is
    // not yet full; start on the same edge wins and the sample is dropped.
    always_ff @(posedge clk100) begin
        if (rst) begin
            state      <= IDLE;
            acc0_i     <= '0;
            acc0_q     <= '0;
            acc1_i     <= '0;
            acc1_q     <= '0;
            cnt0       <= '0;
            cnt1       <= '0;
            i_pt_line  <= '0;
            q_pt_line  <= '0;
            i_vec_perp <= '0;
            q_vec_perp <= '0;
            cal_valid  <= 1'b0;
            busy       <= 1'b0;
        end else if (start && state != COMPUTE) begin
            state     <= COLLECT;
            acc0_i    <= '0;
            acc0_q    <= '0;
            acc1_i    <= '0;
            acc1_q    <= '0;
            cnt0      <= '0;
            cnt1      <= '0;
            cal_valid <= 1'b0;
            busy      <= 1'b1;
        end else begin
            case (state)
                COLLECT: begin
                    if (data_in) begin
                        if (!label && cnt0 != FULL) begin
                            acc0_i <= acc0_i + ext_i;
                            acc0_q <= acc0_q + ext_q;
                            cnt0   <= cnt0 + ONE;
                        end else if (label && cnt1 != FULL) begin
                            acc1_i <= acc1_i + ext_i;
                            acc1_q <= acc1_q + ext_q;
                            cnt1   <= cnt1 + ONE;
                        end
                    end
                    if (cnt0 == FULL && cnt1 == FULL) begin
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    i_pt_line  <= pt_i;
                    q_pt_line  <= pt_q;
                    i_vec_perp <= vec_i;
                    q_vec_perp <= vec_q;
                    cal_valid  <= 1'b1;
                    busy       <= 1'b0;
                    state      <= DONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_classify_calibrate.sv
// Bench for classify_calibrate (LOG2_N=2): spec vector table, multi-cycle corner
// sequences and randomized runs scored against a floor-division centroid model.
module tb_classify_calibrate;
    localparam int LOG2_N = 2;
    localparam int N = 4;

    logic               clk100;
    logic               rst;
    logic               start;
    logic               data_in;
    logic               label;
    logic signed [31:0] i_val;
    logic signed [31:0] q_val;
    logic signed [31:0] i_pt_line;
    logic signed [31:0] q_pt_line;
    logic signed [31:0] i_vec_perp;
    logic signed [31:0] q_vec_perp;
    logic               cal_valid;
    logic               busy;

    classify_calibrate #(.LOG2_N(LOG2_N)) dut (
        .clk100     (clk100),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .label      (label),
        .i_val      (i_val),
        .q_val      (q_val),
        .i_pt_line  (i_pt_line),
        .q_pt_line  (q_pt_line),
        .i_vec_perp (i_vec_perp),
        .q_vec_perp (q_vec_perp),
        .cal_valid  (cal_valid),
        .busy       (busy)
    );

    // clock / reset
    initial begin
        clk100 = 1'b0;
        forever #5 clk100 = ~clk100;
    end

    typedef struct packed {
        logic [3:0]        n;
        logic [11:0]       lab;
        logic [11:0][31:0] iv;
        logic [11:0][31:0] qv;
        logic [127:0]      exp;
    } vec_t;

    vec_t         tbl [4];
    logic [127:0] exp_q [$];
    logic [127:0] last_exp;
    int           errors;
    int           checks;

    // driver tasks
    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic lab, input logic [31:0] iv, input logic [31:0] qv);
        data_in = 1'b1;
        label   = lab;
        i_val   = iv;
        q_val   = qv;
        tick();
        data_in = 1'b0;
    endtask

    task automatic add_samp(input int c, input logic lab, input int iv, input int qv);
        tbl[c].lab[tbl[c].n] = lab;
        tbl[c].iv[tbl[c].n]  = iv;
        tbl[c].qv[tbl[c].n]  = qv;
        tbl[c].n             = tbl[c].n + 4'd1;
    endtask

    // scoreboard
    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [127:0] e);
        check({tag, " i_pt_line"},  i_pt_line,  e[127:96]);
        check({tag, " q_pt_line"},  q_pt_line,  e[95:64]);
        check({tag, " i_vec_perp"}, i_vec_perp, e[63:32]);
        check({tag, " q_vec_perp"}, q_vec_perp, e[31:0]);
    endtask

    task automatic check_flags(input string tag, input logic b, input logic v);
        check({tag, " busy"},      32'(busy),      32'(b));
        check({tag, " cal_valid"}, 32'(cal_valid), 32'(v));
    endtask

    // After the edge that took the final sample: one COMPUTE cycle, then results.
    task automatic finish_run(input string tag, input bit poke_start);
        logic [127:0] e;
        tick();
        check_flags({tag, " compute"}, 1'b1, 1'b0);
        if (poke_start) start = 1'b1;
        tick();
        start = 1'b0;
        check_flags({tag, " done"}, 1'b0, 1'b1);
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_out(tag, e);
            last_exp = e;
        end
    endtask

    task automatic run_table(input int c, input bit poke_start);
        exp_q.push_back(tbl[c].exp);
        do_start();
        check_flags($sformatf("tbl%0d start", c), 1'b1, 1'b0);
        check_out($sformatf("tbl%0d hold", c), last_exp);
        for (int k = 0; k < int'(tbl[c].n); k++) begin
            send(tbl[c].lab[k], tbl[c].iv[k], tbl[c].qv[k]);
        end
        finish_run($sformatf("tbl%0d", c), poke_start);
    endtask

    // reference model: floor division of the class sums by N
    function automatic longint floor_div(input longint a, input longint d);
        longint q;
        q = a / d;
        if ((a % d) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic logic [127:0] model(input longint si0, input longint sq0,
                                           input longint si1, input longint sq1);
        int c0i, c0q, c1i, c1q, pti, ptq, vi, vq;
        c0i = int'(floor_div(si0, N));
        c0q = int'(floor_div(sq0, N));
        c1i = int'(floor_div(si1, N));
        c1q = int'(floor_div(sq1, N));
        pti = int'(floor_div(longint'(c0i) + longint'(c1i), 2));
        ptq = int'(floor_div(longint'(c0q) + longint'(c1q), 2));
        vi  = c1i - c0i;
        vq  = c1q - c0q;
        return {pti, ptq, vi, vq};
    endfunction

    task automatic random_run(input int r);
        longint si [2];
        longint sq [2];
        int     cnt [2];
        int     lab, iv, qv, guard;
        si    = '{0, 0};
        sq    = '{0, 0};
        cnt   = '{0, 0};
        guard = 0;
        do_start();
        check_flags($sformatf("rnd%0d start", r), 1'b1, 1'b0);
        while (!(cnt[0] == N && cnt[1] == N) && guard < 200) begin
            guard++;
            if ($urandom_range(0, 3) == 0) begin
                tick();
            end else begin
                lab = int'($urandom_range(0, 1));
                iv  = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
                qv  = $urandom_range(0, 1) ? int'($urandom) : int'($urandom_range(0, 200)) - 100;
                send(lab[0], iv, qv);
                if (cnt[lab] < N) begin
                    si[lab] += longint'(iv);
                    sq[lab] += longint'(qv);
                    cnt[lab]++;
                end
            end
        end
        exp_q.push_back(model(si[0], sq[0], si[1], sq[1]));
        finish_run($sformatf("rnd%0d", r), 1'b0);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        last_exp = '0;
        rst      = 1'b1;
        start    = 1'b0;
        data_in  = 1'b0;
        label    = 1'b0;
        i_val    = '0;
        q_val    = '0;

        for (int c = 0; c < 4; c++) tbl[c] = '0;
        for (int k = 0; k < 4; k++) add_samp(0, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) add_samp(0, 1'b1, 0, 10);
        tbl[0].exp = {32'(0), 32'(5), 32'(0), 32'(10)};
        for (int k = 0; k < 4; k++) begin
            add_samp(1, 1'b0, -8, -4);
            add_samp(1, 1'b1, 8, 4);
        end
        tbl[1].exp = {32'(0), 32'(0), 32'(16), 32'(8)};
        add_samp(2, 1'b0, -1, 0);
        add_samp(2, 1'b0, -1, 0);
        add_samp(2, 1'b0, -1, 0);
        add_samp(2, 1'b0, -2, 0);
        for (int k = 0; k < 4; k++) add_samp(2, 1'b1, 3, 0);
        tbl[2].exp = {32'(0), 32'(0), 32'(5), 32'(0)};
        for (int k = 0; k < 6; k++) add_samp(3, 1'b0, 100, 0);
        for (int k = 0; k < 4; k++) add_samp(3, 1'b1, 0, 0);
        tbl[3].exp = {32'(50), 32'(0), 32'(-100), 32'(0)};

        tick();
        tick();
        check_flags("reset", 1'b0, 1'b0);
        check_out("reset", 128'd0);
        rst = 1'b0;

        // samples before any start are ignored
        for (int k = 0; k < 10; k++) send(k[0], 500, 500);
        tick();
        check_flags("idle samples", 1'b0, 1'b0);
        check_out("idle samples", 128'd0);

        run_table(0, 1'b0);
        run_table(1, 1'b0);
        run_table(2, 1'b1);   // start during COMPUTE must be ignored
        run_table(3, 1'b0);

        // samples in DONE leave the result untouched
        for (int k = 0; k < 5; k++) send(k[0], 777, -777);
        tick();
        check_flags("done samples", 1'b0, 1'b1);
        check_out("done samples", last_exp);

        // restart mid-collect; the sample on the restart edge is discarded
        exp_q.push_back(tbl[0].exp);
        do_start();
        send(1'b0, 40, 40);
        send(1'b1, -40, 12);
        send(1'b0, 40, 40);
        data_in = 1'b1;
        label   = 1'b0;
        i_val   = 1000;
        q_val   = 1000;
        do_start();
        data_in = 1'b0;
        check_flags("restart", 1'b1, 1'b0);
        check_out("restart hold", last_exp);
        for (int k = 0; k < 8; k++) send(tbl[0].lab[k], tbl[0].iv[k], tbl[0].qv[k]);
        finish_run("restart", 1'b0);

        for (int r = 0; r < 20; r++) random_run(r);

        // reset mid-collect clears everything, later samples without start ignored
        do_start();
        send(1'b0, 9, 9);
        send(1'b1, 9, 9);
        send(1'b0, 9, 9);
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        last_exp = '0;
        check_flags("mid rst", 1'b0, 1'b0);
        check_out("mid rst", 128'd0);
        for (int k = 0; k < 10; k++) send(k[0], 321, -321);
        tick();
        tick();
        check_flags("post rst", 1'b0, 1'b0);
        check_out("post rst", 128'd0);

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries, expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
